// File: rtl/addsub_pkg.sv
// Shared types and constants for the slice-serial adder/subtractor.
package addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} addsub_state_t;
  localparam int SLICE_W = 4;
endpackage

// File: rtl/addsub_slice4.sv
// 4-bit combinational add slice with full lookahead carries from cin.
module addsub_slice4
  import addsub_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a4,
  input  logic [SLICE_W-1:0] i_b4,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_sum4,
  output logic [SLICE_W-1:0] o_c
);
  logic [SLICE_W-1:0] w_g, w_p;

  assign w_g = i_a4 & i_b4;
  assign w_p = i_a4 ^ i_b4;

  assign o_c[0] = w_g[0] | (w_p[0] & i_cin);
  assign o_c[1] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign o_c[2] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign o_c[3] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum4 = w_p ^ {o_c[2:0], i_cin};
endmodule

// File: rtl/block_serial_addsub.sv
// WIDTH-bit add/sub that walks one 4-bit slice per cycle, LSB first,
// with the inter-slice carry held in a register.
module block_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_chk
    $error("block_serial_addsub: WIDTH must be a positive multiple of 4");
  end

  addsub_state_t      r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_a, r_b, r_result, w_res_nxt;
  logic               r_carry, r_cout, r_ovf, r_zero;
  logic [CNT_W-1:0]   r_cnt;
  logic [SLICE_W-1:0] w_a4, w_b4, w_sum4, w_c;
  logic               w_last;

  assign w_a4   = r_a[SLICE_W*r_cnt +: SLICE_W];
  assign w_b4   = r_b[SLICE_W*r_cnt +: SLICE_W];
  assign w_last = (r_cnt == CNT_W'(NSLICE - 1));

  addsub_slice4 u_slice (
    .i_a4  (w_a4),
    .i_b4  (w_b4),
    .i_cin (r_carry),
    .o_sum4(w_sum4),
    .o_c   (w_c)
  );

  // Full result as it will look after this cycle's slice write; zero flag uses it.
  always_comb begin
    w_res_nxt = r_result;
    w_res_nxt[SLICE_W*r_cnt +: SLICE_W] = w_sum4;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= a;
          r_b     <= b ^ {WIDTH{sub}};
          r_carry <= sub;
          r_cnt   <= '0;
        end
        RUN: begin
          r_result <= w_res_nxt;
          r_carry  <= w_c[3];
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_ovf  <= w_c[3] ^ w_c[2];
            r_cout <= w_c[3];
            r_zero <= (w_res_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;
  assign zero      = r_zero;
endmodule

// File: tb/tb_block_serial_addsub.sv
// Directed and randomized bench for block_serial_addsub (WIDTH=32).
module tb_block_serial_addsub;
  logic        clk = 1'b0;
  logic        rst, in_valid, sub, out_ready;
  logic [31:0] a, b;
  logic        in_ready, out_valid, carry_out, overflow, zero;
  logic [31:0] result;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  block_serial_addsub #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  // Present operands, accept, then count edges until out_valid (bounded).
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        input logic isub, output int lat);
    @(negedge clk);
    a = ia; b = ib; sub = isub; in_valid = 1'b1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL op_in_ready got %b want 1", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_op(input int stall);
    repeat (stall) @(posedge clk);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({in_ready, out_valid, carry_out, overflow, zero} !== 5'b10000)
      $display("FAIL reset_flags got %b want 10000", {in_ready, out_valid, carry_out, overflow, zero});
    else n_pass++;
    n_total++;
    if (result !== 32'h0) $display("FAIL reset_result got %h want 00000000", result);
    else n_pass++;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_add_wrap;
    int lat;
    run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, lat);
    n_total++;
    if (lat !== 8) $display("FAIL wrap_latency got %0d want 8", lat);
    else n_pass++;
    n_total++;
    if (result !== 32'h0) $display("FAIL wrap_result got %h want 00000000", result);
    else n_pass++;
    n_total++;
    if ({carry_out, zero, overflow} !== 3'b110)
      $display("FAIL wrap_flags c/z/v got %b want 110", {carry_out, zero, overflow});
    else n_pass++;
    release_op(0);
  endtask

  task automatic test_add_ovf;
    int lat;
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
    n_total++;
    if (result !== 32'h8000_0000) $display("FAIL ovf_result got %h want 80000000", result);
    else n_pass++;
    n_total++;
    if ({carry_out, zero, overflow} !== 3'b001)
      $display("FAIL ovf_flags c/z/v got %b want 001", {carry_out, zero, overflow});
    else n_pass++;
    release_op(0);
  endtask

  task automatic test_sub;
    int lat;
    run_op(32'd5, 32'd7, 1'b1, lat);
    n_total++;
    if (result !== 32'hFFFF_FFFE) $display("FAIL sub_borrow_result got %h want fffffffe", result);
    else n_pass++;
    n_total++;
    if ({carry_out, zero, overflow} !== 3'b000)
      $display("FAIL sub_borrow_flags c/z/v got %b want 000", {carry_out, zero, overflow});
    else n_pass++;
    release_op(0);
    run_op(32'h8000_0000, 32'd1, 1'b1, lat);
    n_total++;
    if (result !== 32'h7FFF_FFFF) $display("FAIL sub_ovf_result got %h want 7fffffff", result);
    else n_pass++;
    n_total++;
    if ({carry_out, zero, overflow} !== 3'b101)
      $display("FAIL sub_ovf_flags c/z/v got %b want 101", {carry_out, zero, overflow});
    else n_pass++;
    release_op(0);
  endtask

  task automatic test_backpressure;
    int lat;
    run_op(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid; a = 32'hDEAD_0000 + i; b = 32'h0; sub = 1'b1;
      @(posedge clk); #1;
      n_total++;
      if ({out_valid, in_ready, result, carry_out, zero, overflow} !== {2'b10, 32'h1010_1010, 3'b000})
        $display("FAIL bp_hold[%0d] got v=%b r=%b res=%h czv=%b want v=1 r=0 res=10101010 czv=000",
                 i, out_valid, in_ready, result, {carry_out, zero, overflow});
      else n_pass++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_total++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL bp_release got ready/valid %b want 10", {in_ready, out_valid});
    else n_pass++;
  endtask

  task automatic test_reset_mid_run;
    int  lat;
    logic seen;
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'h1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if ({in_ready, out_valid} !== 2'b10 || result !== 32'h0)
      $display("FAIL midrun_reset got ready/valid %b res %h want 10 00000000", {in_ready, out_valid}, result);
    else n_pass++;
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL midrun_no_result got out_valid seen=%b want 0", seen);
    else n_pass++;
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, lat);
    n_total++;
    if (lat !== 8 || result !== 32'h2345_6789)
      $display("FAIL post_reset_op got lat %0d res %h want 8 23456789", lat, result);
    else n_pass++;
    release_op(0);
  endtask

  task automatic test_random;
    int          lat;
    logic [31:0] ra, rb, bx, er;
    logic        rs, ec, eo, ez;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      if (i % 50 == 0) rb = rs ? ra : -ra;
      bx = rb ^ {32{rs}};
      {ec, er} = {1'b0, ra} + {1'b0, bx} + 33'(rs);
      eo = (ra[31] == bx[31]) && (er[31] != ra[31]);
      ez = (er == 32'h0);
      run_op(ra, rb, rs, lat);
      n_total++;
      if ({lat == 8, result, carry_out, overflow, zero} !== {1'b1, er, ec, eo, ez})
        $display("FAIL random[%0d] a=%h b=%h sub=%b got lat=%0d res=%h c=%b v=%b z=%b want lat=8 res=%h c=%b v=%b z=%b",
                 i, ra, rb, rs, lat, result, carry_out, overflow, zero, er, ec, eo, ez);
      else n_pass++;
      release_op($urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_add_ovf();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
